// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage.
// FSM state encoding and the buffered fetch entry layout.
package fetch_types;

    localparam int FETCH_ADDR_W = 11;
    localparam int FETCH_DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO holding fetched instructions.
// Flush clears pointers and count and wins over push/pop.
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~flush_i;
    assign pop_ok  = pop_i & ~flush_i & ~empty_o;

    // Pointer and occupancy next-state
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers; storage cleared so head reads 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, ROM issue with FIFO credit, prefetch buffer.
// Redirect flushes buffered and in-flight fetches and restarts the PC.
module fetch_unit
    import fetch_types::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = DATA_W + ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;
    logic              kill_q;
    logic [CNT_W:0]    credit;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_wdata;
    logic [ENT_W-1:0]  fifo_rdata;

    // Outstanding slots: buffered entries plus the read in flight
    assign credit = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: issue only when running, not redirecting, and a slot is free
    always_comb begin
        mem_en = 1'b0;
        if (state_q == RUN && !redirect && credit < (CNT_W+1)'(DEPTH))
            mem_en = 1'b1;
    end

    // PC next state; redirect wins, increment wraps naturally
    always_comb begin
        pc_d = pc_q;
        if (redirect)    pc_d = redirect_addr;
        else if (mem_en) pc_d = pc_q + 1'b1;
    end

    // PC and in-flight read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= mem_en;
            kill_q     <= redirect & (inflight_q | mem_en);
            if (mem_en) inflight_pc_q <= pc_q;
        end
    end

    assign mem_addr    = pc_q;
    assign fifo_push   = inflight_q & ~kill_q;
    assign fifo_pop    = instr_valid & instr_ready;
    assign fifo_wdata  = {mem_data, inflight_pc_q};
    assign instr_valid = ~fifo_empty;
    assign {instr, instr_pc} = fifo_rdata;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// ROM model, in-order scoreboard, redirect table, hand-written corner cases.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] mem_addr;
    logic        mem_en;
    logic [7:0]  mem_data;
    logic        redirect;
    logic [10:0] redirect_addr;
    logic [7:0]  instr;
    logic [10:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  instr;
        logic [10:0] pc;
    } exp_t;

    typedef struct {
        logic [10:0] addr;
        logic        stalled;
        int          lat;
    } vec_t;

    exp_t        sb_q[$];
    logic [10:0] sb_tail;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(11), .DATA_W(8), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mem_addr      (mem_addr),
        .mem_en        (mem_en),
        .mem_data      (mem_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    function automatic logic [7:0] rom(input logic [10:0] a);
        logic [10:0] s;
        s = a + 11'h010;
        return s[7:0];
    endfunction

    // Synchronous ROM: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (mem_en) mem_data <= rom(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_push_tail();
        exp_t e;
        e.instr = rom(sb_tail);
        e.pc    = sb_tail;
        sb_q.push_back(e);
        sb_tail = sb_tail + 11'd1;
    endtask

    // Compare each accepted instruction in order; restart expectations on flush
    task automatic sb_step();
        exp_t e;
        chk("no_overflow", {31'd0, dut.fifo_push & dut.fifo_full}, 32'd0);
        if (instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("sb_instr", {24'd0, instr}, {24'd0, e.instr});
                chk("sb_pc", {21'd0, instr_pc}, {21'd0, e.pc});
                sb_push_tail();
            end
        end
        if (rst || redirect) begin
            sb_q.delete();
            sb_tail = rst ? 11'd0 : redirect_addr;
            repeat (8) sb_push_tail();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_mem_addr"}, {21'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, {24'd0, instr}, 32'd0);
        chk({tag, "_pc"}, {21'd0, instr_pc}, 32'd0);
    endtask

    // Called right after en rises or reset releases with en high
    task automatic first_valid(input string tag, input logic [10:0] pc);
        int lat;
        lat = 0;
        @(negedge clk);
        while (!instr_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_pc"}, {21'd0, instr_pc}, {21'd0, pc});
    endtask

    task automatic count_valid(input string tag, input int n);
        int got;
        got = 0;
        repeat (n) begin
            @(negedge clk);
            if (instr_valid) got++;
        end
        chk({tag, "_rate"}, got, n);
    endtask

    task automatic do_redirect(input logic [10:0] a, input int exp_lat);
        int lat;
        redirect      = 1'b1;
        redirect_addr = a;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        lat = 1;
        @(negedge clk);
        chk("flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("flush_count", {29'd0, dut.u_fifo.count_o}, 32'd0);
        while (!instr_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("redir_lat", lat, exp_lat);
        chk("redir_pc", {21'd0, instr_pc}, {21'd0, a});
        step();
    endtask

    initial begin
        vec_t        vecs[4];
        logic [10:0] wrap_exp[4];
        logic [10:0] wrap_got[4];
        int          n;
        int          guard;

        vecs[0] = '{addr: 11'h123, stalled: 1'b1, lat: 3};
        vecs[1] = '{addr: 11'h040, stalled: 1'b0, lat: 3};
        vecs[2] = '{addr: 11'h000, stalled: 1'b0, lat: 3};
        vecs[3] = '{addr: 11'h3FF, stalled: 1'b1, lat: 3};
        wrap_exp[0] = 11'h7FE;
        wrap_exp[1] = 11'h7FF;
        wrap_exp[2] = 11'h000;
        wrap_exp[3] = 11'h001;

        rst           = 1'b1;
        en            = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        instr_ready   = 1'b1;

        fork
            forever begin
                @(negedge clk);
                sb_step();
            end
        join_none

        repeat (3) step();
        chk_reset_outs("reset");
        rst = 1'b0;
        step();

        // Startup stream
        en = 1'b1;
        first_valid("start", 11'h000);
        count_valid("start", 8);

        // Back-pressure fills the FIFO and stops issue
        step();
        instr_ready = 1'b0;
        repeat (10) step();
        chk("stall_mem_en", {31'd0, mem_en}, 32'd0);
        chk("stall_count", {29'd0, dut.u_fifo.count_o}, 32'd4);
        chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        count_valid("release", 10);
        step();

        // Redirect table
        foreach (vecs[i]) begin
            if (vecs[i].stalled) begin
                instr_ready = 1'b0;
                guard = 0;
                step();
                while (!(dut.u_fifo.count_o == 3 && dut.inflight_q) && guard < 10) begin
                    step();
                    guard++;
                end
                chk("redir_setup", guard < 10, 1);
            end else begin
                chk("pop_redir_valid", {31'd0, instr_valid}, 32'd1);
            end
            do_redirect(vecs[i].addr, vecs[i].lat);
            count_valid("post_redir", 6);
            step();
        end

        // Wrap at the top of the address space
        do_redirect(11'h7FE, 3);
        n = 1;
        wrap_got[0] = 11'h7FE;
        guard = 0;
        while (n < 4 && guard < 30) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                wrap_got[n] = instr_pc;
                n++;
            end
            guard++;
        end
        chk("wrap_count", n, 4);
        for (int i = 1; i < 4; i++)
            chk("wrap_pc", {21'd0, wrap_got[i]}, {21'd0, wrap_exp[i]});
        step();

        // Redirect while idle only moves the PC
        en = 1'b0;
        repeat (8) step();
        chk("idle_valid", {31'd0, instr_valid}, 32'd0);
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
        redirect      = 1'b1;
        redirect_addr = 11'h200;
        step();
        redirect = 1'b0;
        chk("idle_redir_pc", {21'd0, mem_addr}, 32'h200);
        chk("idle_redir_en", {31'd0, mem_en}, 32'd0);
        en = 1'b1;
        first_valid("idle_start", 11'h200);
        count_valid("idle_start", 5);
        step();

        // Reset mid-stream
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outs("midrst");
        first_valid("midrst_restart", 11'h000);
        count_valid("midrst", 6);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
